// File: rtl/eth_frame_buffer_ctrl.sv
// Store-and-forward Ethernet RX frame buffer with commit/rollback writes and a frame-length FIFO.
// Define ETH_FB_STATS_EN to enable the saturating dropped-frame counter on o_drop_cnt.
module eth_frame_buffer_ctrl #(
    parameter int DEPTH  = 2048,
    parameter int FRAMES = 16,
    parameter int LEN_W  = 11
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_wvalid,
    input  logic [7:0]  i_wdata,
    input  logic        i_wlast,
    input  logic        i_wbad,
    output logic        o_rvalid,
    output logic [7:0]  o_rdata,
    output logic        o_rlast,
    input  logic        i_rready,
    output logic        o_frame_avail,
    output logic        o_drop,
    output logic [15:0] o_drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(FRAMES);
    // One extra bit so a frame that fills the whole buffer keeps a non-zero length.
    localparam int LW = LEN_W + 1;

    typedef enum logic [1:0] {W_IDLE, W_WRITE, W_DISCARD} wstate_e;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM} rstate_e;

    wstate_e         wstate_q, wstate_d;
    rstate_e         rstate_q, rstate_d;
    logic [AW:0]     wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   wlen_q, wlen_d, rem_q, rem_d, len_now;
    logic [FW:0]     lf_wp_q, lf_wp_d, lf_rp_q, lf_rp_d;
    logic            drop_q, drop_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [7:0]      rdata_q;

    logic [7:0]      mem [DEPTH];
    logic [LW-1:0]   lf_mem [FRAMES];
    logic            mem_we, rden, lf_push, lf_pop;
    logic [AW-1:0]   raddr;
    logic [AW:0]     used;
    logic [FW:0]     lf_count;
    logic            buf_full, lf_full, lf_empty;

    assign used     = wr_ptr_q - rd_ptr_q;
    assign buf_full = (used == (AW+1)'(DEPTH));
    assign lf_count = lf_wp_q - lf_rp_q;
    assign lf_full  = (lf_count == (FW+1)'(FRAMES));
    assign lf_empty = (lf_wp_q == lf_rp_q);
    assign len_now  = (wstate_q == W_IDLE) ? LW'(1) : wlen_q + LW'(1);

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case can infer a latch.
        wstate_d     = wstate_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        wlen_d       = wlen_q;
        mem_we       = 1'b0;
        lf_push      = 1'b0;
        drop_d       = 1'b0;
        unique case (wstate_q)
            W_IDLE, W_WRITE: begin
                if (i_wvalid && buf_full) begin
                    if (i_wlast) begin
                        wr_ptr_d = commit_ptr_q;
                        drop_d   = 1'b1;
                        wstate_d = W_IDLE;
                    end else begin
                        wstate_d = W_DISCARD;
                    end
                end else if (i_wvalid) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    wlen_d   = len_now;
                    wstate_d = W_WRITE;
                    if (i_wlast) begin
                        wstate_d = W_IDLE;
                        if (!i_wbad && !lf_full) begin
                            lf_push      = 1'b1;
                            commit_ptr_d = wr_ptr_q + 1'b1;
                        end else begin
                            wr_ptr_d = commit_ptr_q;
                            drop_d   = 1'b1;
                        end
                    end
                end
            end
            W_DISCARD: begin
                if (i_wvalid && i_wlast) begin
                    wr_ptr_d = commit_ptr_q;
                    drop_d   = 1'b1;
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_d = rstate_q;
        rd_ptr_d = rd_ptr_q;
        rem_d    = rem_q;
        rvalid_d = rvalid_q;
        rlast_d  = rlast_q;
        rden     = 1'b0;
        raddr    = rd_ptr_q[AW-1:0];
        lf_pop   = 1'b0;
        unique case (rstate_q)
            R_IDLE: begin
                if (!lf_empty) begin
                    lf_pop   = 1'b1;
                    rem_d    = lf_mem[lf_rp_q[FW-1:0]];
                    rstate_d = R_FETCH;
                end
            end
            R_FETCH: begin
                rden     = 1'b1;
                rvalid_d = 1'b1;
                rlast_d  = (rem_q == LW'(1));
                rstate_d = R_STREAM;
            end
            R_STREAM: begin
                if (i_rready) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    rem_d    = rem_q - LW'(1);
                    if (rem_q > LW'(1)) begin
                        // Prefetch the next byte now so a ready sink sees one byte per cycle.
                        rden    = 1'b1;
                        raddr   = rd_ptr_q[AW-1:0] + AW'(1);
                        rlast_d = (rem_q == LW'(2));
                    end else begin
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                        if (!lf_empty) begin
                            lf_pop   = 1'b1;
                            rem_d    = lf_mem[lf_rp_q[FW-1:0]];
                            rstate_d = R_FETCH;
                        end else begin
                            rstate_d = R_IDLE;
                        end
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    assign lf_wp_d = lf_push ? lf_wp_q + 1'b1 : lf_wp_q;
    assign lf_rp_d = lf_pop  ? lf_rp_q + 1'b1 : lf_rp_q;

    // NOTE: storage arrays carry no reset; the pointers alone decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (mem_we)  mem[wr_ptr_q[AW-1:0]] <= i_wdata;
        if (lf_push) lf_mem[lf_wp_q[FW-1:0]] <= len_now;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)     rdata_q <= '0;
        else if (rden) rdata_q <= mem[raddr];
    end

    // NOTE: state registers use non-blocking assignment only; next-state logic above is blocking.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wstate_q     <= W_IDLE;
            rstate_q     <= R_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            wlen_q       <= '0;
            rem_q        <= '0;
            lf_wp_q      <= '0;
            lf_rp_q      <= '0;
            drop_q       <= 1'b0;
            rvalid_q     <= 1'b0;
            rlast_q      <= 1'b0;
        end else begin
            wstate_q     <= wstate_d;
            rstate_q     <= rstate_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            wlen_q       <= wlen_d;
            rem_q        <= rem_d;
            lf_wp_q      <= lf_wp_d;
            lf_rp_q      <= lf_rp_d;
            drop_q       <= drop_d;
            rvalid_q     <= rvalid_d;
            rlast_q      <= rlast_d;
        end
    end

`ifdef ETH_FB_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    assign drop_cnt_d = (drop_d && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) drop_cnt_q <= '0;
        else       drop_cnt_q <= drop_cnt_d;
    end
    assign o_drop_cnt = drop_cnt_q;
`else
    assign o_drop_cnt = '0;
`endif

    assign o_rvalid      = rvalid_q;
    assign o_rdata       = rdata_q;
    assign o_rlast       = rlast_q;
    assign o_drop        = drop_q;
    assign o_frame_avail = !lf_empty || (rstate_q != R_IDLE);

endmodule
